dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder: the memory end of the DM_* interface driven by the processor datapath.
- Services one read or one write at a time, with a parameterised wait-state latency.
- Provides a ready/error handshake so a stall-capable core can wait on it.
- Replaces the zero-latency combinational data memory in the top-level processor; instruction memory is unaffected.

Parameters:
- N, 64, data and address width in bits.
- DEPTH, 32, number of N-bit words stored.
- LATENCY, 2, cycles from request sample to DM_ready pulse; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- DM_addr  input  N  byte address from execute stage ALU result.
- DM_writeData  input  N  store data.
- DM_writeEnable  input  1  store request.
- DM_readEnable  input  1  load request.
- DM_readData  output  N  load data; valid when DM_ready=1 and DM_error=0.
- DM_ready  output  1  one-cycle completion pulse.
- DM_busy  output  1  high from request sample until the cycle before DM_ready; core stall source.
- DM_error  output  1  qualifies DM_ready; access rejected.

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE.
  - DM_readData=0, DM_ready=0, DM_busy=0, DM_error=0, latency counter=0.
  - Memory is initialised to mem[i]=i.
  - Any pending request is discarded, including an uncommitted write.
- Word index = DM_addr[N-1:3]. An access is illegal if DM_addr[2:0]!=0, if index>=DEPTH, or if both enables are high.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If either enable is high at a rising edge, capture addr, data, op and an illegal flag.
  - If LATENCY==1, go to DONE; otherwise go to BUSY with counter=LATENCY-1.
  - If neither enable is high, stay in IDLE.
- BUSY:
  - DM_busy=1. Decrement the counter each edge.
  - When the counter reaches 1, go to DONE on that edge.
  - Enables are ignored while BUSY; captured values are used.
- Commit on the edge entering DONE:
  - Legal write: mem[index] <= captured data.
  - Legal read: DM_readData <= mem[index].
  - Illegal access: no memory or DM_readData change; DM_error=1 in DONE.
- DONE:
  - DM_ready=1 for exactly one cycle; DM_error is valid in the same cycle.
  - Unconditionally return to IDLE. Enables sampled in DONE are ignored.
  - The core must drop or replace its request in this cycle; a still-held request is re-sampled in the following IDLE cycle.
- Cycle-level latency: request present in cycle t gives DM_ready in cycle t+LATENCY.
  - Back-to-back throughput is one access per LATENCY+1 cycles.
- DM_readData holds its last read value until the next legal read commits. Writes never change it.
- DM_busy, DM_ready and DM_error are registered, decoded from state; there is no combinational path from inputs to them.
- Read-after-write to the same address returns the new value, because accesses are serialised.
- Reset asserted during BUSY or DONE aborts the access: no write occurs and DM_ready does not pulse.

Decomposition:
- Package dmem_pkg holds:
  - typedef enum logic [1:0] {IDLE, BUSY, DONE} dmem_state_t.
  - typedef enum logic {OP_READ, OP_WRITE} dmem_op_t.
  - localparam DMEM_DEFAULT_DEPTH=32.
  - localparam DMEM_MAX_LATENCY=15.
- One natural sub-module, dmem_array: DEPTH x N storage with registered read port, single write port and the reset-time initialisation.
- FSM, capture registers, legality check and latency counter live in dmem_responder.

Test Plan:
- Reset then read addr 0x18 (LATENCY=2), readEnable high in cycle t -> DM_busy=1 in t+1, DM_ready=1 and DM_readData=3 in t+2, DM_error=0.
- Write 0xDEADBEEF_CAFEF00D to 0x40, then read 0x40 -> second access returns 0xDEADBEEF_CAFEF00D; mem[7] still reads 7.
- Misaligned read at 0x1C, then out-of-range write at 0x100 (DEPTH=32) -> each gives DM_ready=1 with DM_error=1; DM_readData keeps its prior value; mem unchanged.
- Both enables high at addr 0x08 -> DM_error=1 at t+LATENCY, mem[1] remains 1.
- Assert reset during BUSY of a write of 0x55 to 0x10 -> outputs 0 immediately, no DM_ready pulse, subsequent read of 0x10 returns 2.
- Sweep LATENCY=1 and 15 with a held readEnable -> DM_ready pulses exactly every LATENCY+1 cycles, DM_busy never overlaps DM_ready.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder.
//   dmem_state_t       : responder FSM states (IDLE, BUSY, DONE)
//   dmem_op_t          : captured access kind (read or write)
//   DMEM_DEFAULT_DEPTH : default number of stored words
//   DMEM_MAX_LATENCY   : largest supported wait-state latency
package dmem_pkg;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} dmem_state_t;

   typedef enum logic {OP_READ, OP_WRITE} dmem_op_t;

   localparam int unsigned DMEM_DEFAULT_DEPTH = 32;
   localparam int unsigned DMEM_MAX_LATENCY   = 15;

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: DM_* bus between the processor datapath (master) and
// the data-memory responder (slave).
//   DM_addr        : byte address, master -> slave
//   DM_writeData   : store data, master -> slave
//   DM_writeEnable : store request, master -> slave
//   DM_readEnable  : load request, master -> slave
//   DM_readData    : load data, slave -> master
//   DM_ready       : one-cycle completion pulse, slave -> master
//   DM_busy        : access in progress (stall source), slave -> master
//   DM_error       : qualifies DM_ready, access rejected, slave -> master
interface dmem_responder_if #(
   parameter int unsigned N = 64
);
   logic [N-1:0] DM_addr;
   logic [N-1:0] DM_writeData;
   logic         DM_writeEnable;
   logic         DM_readEnable;
   logic [N-1:0] DM_readData;
   logic         DM_ready;
   logic         DM_busy;
   logic         DM_error;

   modport master (
      output DM_addr, DM_writeData, DM_writeEnable, DM_readEnable,
      input  DM_readData, DM_ready, DM_busy, DM_error
   );

   modport slave (
      input  DM_addr, DM_writeData, DM_writeEnable, DM_readEnable,
      output DM_readData, DM_ready, DM_busy, DM_error
   );

endinterface

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x N word storage with one write port and one registered
// read port sharing a single word address.
//   clk     : system clock, rising edge
//   reset   : asynchronous active-low reset; loads mem[i]=i, clears rdata_o
//   we_i    : write strobe, stores wdata_i at addr_i
//   re_i    : read strobe, registers mem[addr_i] into rdata_o
//   addr_i  : word address
//   wdata_i : write data
//   rdata_o : read data, holds until the next read strobe
module dmem_array #(
   parameter int unsigned N     = 64,
   parameter int unsigned DEPTH = 32,
   parameter int unsigned AW    = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we_i,
   input  logic          re_i,
   input  logic [AW-1:0] addr_i,
   input  logic [N-1:0]  wdata_i,
   output logic [N-1:0]  rdata_o
);

   logic [N-1:0] mem_q [DEPTH];
   logic [N-1:0] rdata_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= N'(i);
         end
      end else if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory end of the DM_* bus. Services one read or write at
// a time with LATENCY cycles from request sample to the DM_ready pulse.
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset; aborts any pending access
//   dm    : DM_* bus, slave side (see dmem_responder_if)
// Parameters: N data/address width, DEPTH words stored, LATENCY 1..15.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned N       = 64,
   parameter int unsigned DEPTH   = DMEM_DEFAULT_DEPTH,
   parameter int unsigned LATENCY = 2
) (
   input logic             clk,
   input logic             reset,
   dmem_responder_if.slave dm
);

   localparam int unsigned   AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned   IW        = N - 3;
   localparam int unsigned   CW        = $clog2(DMEM_MAX_LATENCY + 1);
   localparam logic [IW-1:0] DEPTH_LIM = IW'(DEPTH);
   localparam logic [CW-1:0] CNT_LOAD  = CW'(LATENCY - 1);

   dmem_state_t   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [N-1:0]  data_q, data_d;
   dmem_op_t      op_q, op_d;
   logic          illegal_q, illegal_d;

   logic          req;
   logic          req_illegal;
   logic          commit;
   logic          arr_we;
   logic          arr_re;

   assign req         = dm.DM_writeEnable | dm.DM_readEnable;
   assign req_illegal = (dm.DM_addr[2:0] != 3'b000)
                     || (dm.DM_addr[N-1:3] >= DEPTH_LIM)
                     || (dm.DM_writeEnable && dm.DM_readEnable);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         data_q    <= '0;
         op_q      <= OP_READ;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         data_q    <= data_d;
         op_q      <= op_d;
         illegal_q <= illegal_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      data_d    = data_q;
      op_d      = op_q;
      illegal_d = illegal_q;
      commit    = 1'b0;

      case (state_q)
         IDLE: begin
            if (req) begin
               idx_d     = dm.DM_addr[AW+2:3];
               data_d    = dm.DM_writeData;
               op_d      = dm.DM_writeEnable ? OP_WRITE : OP_READ;
               illegal_d = req_illegal;
               if (LATENCY == 1) begin
                  state_d = DONE;
                  commit  = 1'b1;
               end else begin
                  state_d = BUSY;
                  cnt_d   = CNT_LOAD;
               end
            end
         end
         BUSY: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q <= 1) begin
               state_d = DONE;
               commit  = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // The *_d capture values equal the live request when committing straight
   // from IDLE and the held capture when committing from BUSY, so one
   // expression covers both paths.
   assign arr_we = commit && (op_d == OP_WRITE) && !illegal_d;
   assign arr_re = commit && (op_d == OP_READ)  && !illegal_d;

   dmem_array #(
      .N     (N),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clk     (clk),
      .reset   (reset),
      .we_i    (arr_we),
      .re_i    (arr_re),
      .addr_i  (idx_d),
      .wdata_i (data_d),
      .rdata_o (dm.DM_readData)
   );

   assign dm.DM_busy  = (state_q == BUSY);
   assign dm.DM_ready = (state_q == DONE);
   assign dm.DM_error = (state_q == DONE) && illegal_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized self-checking bench for dmem_responder.
// Main instance uses LATENCY=2; two extra instances (LATENCY=1 and 15)
// check held-request pulse spacing.
module tb_dmem_responder;

   localparam int unsigned N     = 64;
   localparam int unsigned DEPTH = 32;
   localparam int unsigned LAT   = 2;

   logic clk = 1'b0;
   logic rst_n;
   logic rst2_n;

   always #5 clk = ~clk;

   dmem_responder_if #(.N(N)) dm_if ();
   dmem_responder_if #(.N(N)) dm1_if ();
   dmem_responder_if #(.N(N)) dm15_if ();

   dmem_responder #(.N(N), .DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
      .clk   (clk),
      .reset (rst_n),
      .dm    (dm_if.slave)
   );

   dmem_responder #(.N(N), .DEPTH(DEPTH), .LATENCY(1)) u_dut_l1 (
      .clk   (clk),
      .reset (rst2_n),
      .dm    (dm1_if.slave)
   );

   dmem_responder #(.N(N), .DEPTH(DEPTH), .LATENCY(15)) u_dut_l15 (
      .clk   (clk),
      .reset (rst2_n),
      .dm    (dm15_if.slave)
   );

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Behavioural reference: word array plus last read value.
   logic [N-1:0] ref_mem [DEPTH];
   logic [N-1:0] ref_rd;

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = N'(i);
      ref_rd = '0;
   endtask

   // Called #1 after a rising edge; request is present for exactly one cycle.
   task automatic access(input logic we, input logic re,
                         input logic [N-1:0] addr, input logic [N-1:0] data);
      logic [N-1:0] idx;
      bit           illegal;
      idx     = addr >> 3;
      illegal = (addr % 8 != 0) || (idx >= DEPTH) || (we && re);
      dm_if.DM_addr        = addr;
      dm_if.DM_writeData   = data;
      dm_if.DM_writeEnable = we;
      dm_if.DM_readEnable  = re;
      @(posedge clk); #1;
      dm_if.DM_writeEnable = 1'b0;
      dm_if.DM_readEnable  = 1'b0;
      dm_if.DM_addr        = {$urandom, $urandom};
      if (!illegal) begin
         if (we) ref_mem[int'(idx)] = data;
         else    ref_rd = ref_mem[int'(idx)];
      end
      for (int k = 1; k < LAT; k++) begin
         check("busy_wait", dm_if.DM_busy, 1);
         check("ready_early", dm_if.DM_ready, 0);
         @(posedge clk); #1;
      end
      check("ready", dm_if.DM_ready, 1);
      check("busy_done", dm_if.DM_busy, 0);
      check("error", dm_if.DM_error, illegal);
      check("rdata", dm_if.DM_readData, ref_rd);
      @(posedge clk); #1;
      check("ready_drop", dm_if.DM_ready, 0);
   endtask

   initial begin
      logic [N-1:0] a;
      logic [N-1:0] d;
      int unsigned  sel;
      int           last1, last15, np1, np15;

      rst_n  = 1'b0;
      rst2_n = 1'b0;
      dm_if.DM_addr = '0;   dm_if.DM_writeData = '0;
      dm_if.DM_writeEnable = 1'b0; dm_if.DM_readEnable = 1'b0;
      dm1_if.DM_addr = '0;  dm1_if.DM_writeData = '0;
      dm1_if.DM_writeEnable = 1'b0; dm1_if.DM_readEnable = 1'b0;
      dm15_if.DM_addr = '0; dm15_if.DM_writeData = '0;
      dm15_if.DM_writeEnable = 1'b0; dm15_if.DM_readEnable = 1'b0;
      model_reset();

      repeat (2) @(posedge clk);
      #1;
      check("rst_rdata", dm_if.DM_readData, 0);
      check("rst_ready", dm_if.DM_ready, 0);
      check("rst_busy", dm_if.DM_busy, 0);
      check("rst_error", dm_if.DM_error, 0);
      check("rst_l15_ready", dm15_if.DM_ready, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed cases
      access(1'b0, 1'b1, 64'h18, '0);
      check("read18", dm_if.DM_readData, 3);
      access(1'b1, 1'b0, 64'h40, 64'hDEADBEEF_CAFEF00D);
      access(1'b0, 1'b1, 64'h40, '0);
      check("raw40", dm_if.DM_readData, 64'hDEADBEEF_CAFEF00D);
      access(1'b0, 1'b1, 64'h38, '0);
      check("read38", dm_if.DM_readData, 7);
      access(1'b0, 1'b1, 64'h1C, '0);
      check("misalign_hold", dm_if.DM_readData, 7);
      access(1'b1, 1'b0, 64'h100, 64'h1234);
      access(1'b1, 1'b1, 64'h08, 64'hFFFF);
      access(1'b0, 1'b1, 64'h08, '0);
      check("both_en_mem1", dm_if.DM_readData, 1);

      // Reset during BUSY of a write aborts it
      dm_if.DM_addr = 64'h10; dm_if.DM_writeData = 64'h55;
      dm_if.DM_writeEnable = 1'b1;
      @(posedge clk); #1;
      dm_if.DM_writeEnable = 1'b0;
      check("abort_busy", dm_if.DM_busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("abort_busy0", dm_if.DM_busy, 0);
      check("abort_rdata0", dm_if.DM_readData, 0);
      check("abort_error0", dm_if.DM_error, 0);
      model_reset();
      repeat (2) begin
         @(posedge clk); #1;
         check("abort_noready", dm_if.DM_ready, 0);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("abort_noready2", dm_if.DM_ready, 0);
      access(1'b0, 1'b1, 64'h10, '0);
      check("abort_read10", dm_if.DM_readData, 2);

      // Randomized traffic
      for (int t = 0; t < 300; t++) begin
         sel = $urandom_range(0, 9);
         case (sel)
            0: a = N'($urandom_range(0, 255));
            1: a = N'((32 + $urandom_range(0, 100)) << 3);
            2: a = {$urandom, $urandom};
            default: a = N'($urandom_range(0, DEPTH - 1) << 3);
         endcase
         d   = {$urandom, $urandom};
         sel = $urandom_range(0, 9);
         if (sel == 0)      access(1'b1, 1'b1, a, d);
         else if (sel < 5)  access(1'b1, 1'b0, a, d);
         else               access(1'b0, 1'b1, a, d);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
            check("idle_noready", dm_if.DM_ready, 0);
         end
      end

      // Held readEnable on LATENCY=1 and LATENCY=15 instances
      rst2_n = 1'b1;
      dm1_if.DM_addr  = 64'h18; dm1_if.DM_readEnable  = 1'b1;
      dm15_if.DM_addr = 64'h18; dm15_if.DM_readEnable = 1'b1;
      last1 = -1; last15 = -1; np1 = 0; np15 = 0;
      for (int c = 1; c <= 70; c++) begin
         @(posedge clk); #1;
         check("l1_overlap", dm1_if.DM_busy & dm1_if.DM_ready, 0);
         check("l15_overlap", dm15_if.DM_busy & dm15_if.DM_ready, 0);
         if (dm1_if.DM_ready) begin
            check("l1_rdata", dm1_if.DM_readData, 3);
            check("l1_err", dm1_if.DM_error, 0);
            if (last1 < 0) check("l1_first", N'(c), 1);
            else           check("l1_period", N'(c - last1), 2);
            last1 = c; np1++;
         end
         if (dm15_if.DM_ready) begin
            check("l15_rdata", dm15_if.DM_readData, 3);
            check("l15_err", dm15_if.DM_error, 0);
            if (last15 < 0) check("l15_first", N'(c), 15);
            else            check("l15_period", N'(c - last15), 16);
            last15 = c; np15++;
         end
      end
      check("l1_npulse", N'(np1), (70 - 1) / 2 + 1);
      check("l15_npulse", N'(np15), (70 - 15) / 16 + 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
